// File: rtl/rv32i_lsu.sv
// rv32i_lsu: RISC-V load/store unit. Decodes size/sign from func3, drives a
// word-wide data memory port with byte-lane enables, and splits accesses that
// straddle a word boundary into two memory transactions (or rejects them).
module rv32i_lsu #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic                clk_i,
  input  logic                resetn_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [2:0]          func3_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [XLEN-1:0]     wdata_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [XLEN-1:0]     rdata_o,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [ADDR_W-1:0]   dmem_add_o,
  output logic [XLEN-1:0]     dmem_di_o,
  output logic [XLEN/8-1:0]   dmem_ble_o,
  input  logic                dmem_ack_i,
  input  logic [XLEN-1:0]     dmem_do_i
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_e;

  // Encodings the unit refuses: reserved func3, unsigned stores, and
  // doubleword accesses on a 32-bit datapath.
  function automatic logic access_err(input logic [2:0] f3, input logic we);
    return (f3 == 3'b111) || (f3[2] && we) ||
           ((XLEN == 32) && (f3[1:0] == 2'b11)) ||
           ((XLEN == 32) && (f3 == 3'b110));
  endfunction

  // One enable bit per byte of the access, right-aligned.
  function automatic logic [NB-1:0] lane_mask(input logic [1:0] size);
    logic [NB-1:0] m;
    for (int i = 0; i < NB; i++) begin
      m[i] = (i < (1 << size));
    end
    return m;
  endfunction

  // One bit per data bit of the access, right-aligned.
  function automatic logic [XLEN-1:0] bit_mask(input logic [1:0] size);
    logic [XLEN-1:0] m;
    for (int i = 0; i < XLEN; i++) begin
      m[i] = (i < (8 << size));
    end
    return m;
  endfunction

  // Truncate a right-aligned load to its size, then sign- or zero-extend.
  function automatic logic [XLEN-1:0] ld_extend(input logic [XLEN-1:0] raw,
                                                input logic [1:0] size,
                                                input logic uns);
    logic [XLEN-1:0] m;
    logic            sgn;
    m = bit_mask(size);
    case (size)
      2'b00:   sgn = raw[7];
      2'b01:   sgn = raw[15];
      2'b10:   sgn = raw[31];
      default: sgn = raw[XLEN-1];
    endcase
    sgn = sgn & ~uns;
    return (raw & m) | (~m & {XLEN{sgn}});
  endfunction

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic                split_q, split_d;
  logic [NB-1:0]       ble2_q, ble2_d;
  logic [XLEN-1:0]     di2_q, di2_d;
  logic [XLEN-1:0]     lo_q, lo_d;
  logic                dreq_q, dreq_d;
  logic                dwe_q, dwe_d;
  logic [ADDR_W-1:0]   dadd_q, dadd_d;
  logic [XLEN-1:0]     ddi_q, ddi_d;
  logic [NB-1:0]       dble_q, dble_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;

  logic [OFF_W-1:0]    off_s;
  logic [2*NB-1:0]     wide_ble_s;
  logic [2*XLEN-1:0]   wide_di_s;
  logic                mis_s;
  logic                reject_s;
  logic                can_take_s;
  logic                accept_s;
  logic                refuse_s;
  logic [ADDR_W-1:0]   word_addr_s;
  logic [2*XLEN-1:0]   wide_rd_s;
  logic [2*XLEN-1:0]   shifted_s;
  logic [XLEN-1:0]     ld_s;

  // Request decode: lane/data placement across two words and accept/reject.
  always_comb begin
    off_s       = addr_i[OFF_W-1:0];
    wide_ble_s  = {{NB{1'b0}}, lane_mask(func3_i[1:0])} << off_s;
    wide_di_s   = {{XLEN{1'b0}}, (wdata_i & bit_mask(func3_i[1:0]))} << {off_s, 3'b000};
    mis_s       = |wide_ble_s[2*NB-1:NB];
    reject_s    = access_err(func3_i, we_i) || (mis_s && !MISALIGN_EN);
    can_take_s  = (state_q == IDLE) || (state_q == RESP);
    accept_s    = req_i && can_take_s && !reject_s;
    refuse_s    = req_i && can_take_s && reject_s;
    word_addr_s = {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  end

  // Load assembly: little-endian concatenation of both words, shifted down.
  always_comb begin
    if (split_q) begin
      wide_rd_s = {dmem_do_i, lo_q};
    end else begin
      wide_rd_s = {{XLEN{1'b0}}, dmem_do_i};
    end
    shifted_s = wide_rd_s >> {off_q, 3'b000};
    ld_s      = ld_extend(shifted_s[XLEN-1:0], size_q, uns_q);
  end

  // Next-state logic for the FSM, memory port registers and response.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    split_d = split_q;
    ble2_d  = ble2_q;
    di2_d   = di2_q;
    lo_d    = lo_q;
    dreq_d  = dreq_q;
    dwe_d   = dwe_q;
    dadd_d  = dadd_q;
    ddi_d   = ddi_q;
    dble_d  = dble_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept_s) begin
          state_d = ACC1;
          we_d    = we_i;
          size_d  = func3_i[1:0];
          uns_d   = func3_i[2];
          off_d   = off_s;
          split_d = mis_s;
          ble2_d  = wide_ble_s[2*NB-1:NB];
          di2_d   = wide_di_s[2*XLEN-1:XLEN];
          dreq_d  = 1'b1;
          dwe_d   = we_i;
          dadd_d  = word_addr_s;
          dble_d  = wide_ble_s[NB-1:0];
          ddi_d   = wide_di_s[XLEN-1:0];
        end else if (refuse_s) begin
          state_d = RESP;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = {XLEN{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      ACC1: begin
        if (dmem_ack_i) begin
          lo_d = dmem_do_i;
          if (split_q) begin
            state_d = ACC2;
            dadd_d  = dadd_q + ADDR_W'(NB);
            dble_d  = ble2_q;
            ddi_d   = di2_q;
          end else begin
            state_d = RESP;
            dreq_d  = 1'b0;
            dwe_d   = 1'b0;
            done_d  = 1'b1;
            rdata_d = we_q ? {XLEN{1'b0}} : ld_s;
          end
        end else begin
          state_d = ACC1;
        end
      end
      ACC2: begin
        if (dmem_ack_i) begin
          state_d = RESP;
          dreq_d  = 1'b0;
          dwe_d   = 1'b0;
          done_d  = 1'b1;
          rdata_d = we_q ? {XLEN{1'b0}} : ld_s;
        end else begin
          state_d = ACC2;
        end
      end
      default: begin
        state_d = IDLE;
        dreq_d  = 1'b0;
        dwe_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= {OFF_W{1'b0}};
      split_q <= 1'b0;
      ble2_q  <= {NB{1'b0}};
      di2_q   <= {XLEN{1'b0}};
      lo_q    <= {XLEN{1'b0}};
      dreq_q  <= 1'b0;
      dwe_q   <= 1'b0;
      dadd_q  <= {ADDR_W{1'b0}};
      ddi_q   <= {XLEN{1'b0}};
      dble_q  <= {NB{1'b0}};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= {XLEN{1'b0}};
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      split_q <= split_d;
      ble2_q  <= ble2_d;
      di2_q   <= di2_d;
      lo_q    <= lo_d;
      dreq_q  <= dreq_d;
      dwe_q   <= dwe_d;
      dadd_q  <= dadd_d;
      ddi_q   <= ddi_d;
      dble_q  <= dble_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Stall covers the accepting cycle too, so it must see req_i directly.
  assign busy_o     = resetn_i && ((state_q == ACC1) || (state_q == ACC2) || accept_s);
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rdata_o    = rdata_q;
  assign dmem_req_o = dreq_q;
  assign dmem_we_o  = dwe_q;
  assign dmem_add_o = dadd_q;
  assign dmem_di_o  = ddi_q;
  assign dmem_ble_o = dble_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// tb_rv32i_lsu: directed vectors for rv32i_lsu (XLEN=32) with hand-computed
// expectations; a second instance has misaligned splitting disabled.
module tb_rv32i_lsu;

  logic        clk = 1'b0;
  logic        resetn, req, req_n, we, ack;
  logic [2:0]  f3;
  logic [31:0] addr, wdata, do_i;

  logic        busy, done, err, mreq, mwe;
  logic [31:0] rdata, madd, mdi;
  logic [3:0]  mble;
  logic        n_busy, n_done, n_err, n_mreq, n_mwe;
  logic [31:0] n_rdata, n_madd, n_mdi;
  logic [3:0]  n_mble;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  rv32i_lsu #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b1)) u_dut (
    .clk_i(clk), .resetn_i(resetn), .req_i(req), .we_i(we), .func3_i(f3),
    .addr_i(addr), .wdata_i(wdata), .busy_o(busy), .done_o(done), .err_o(err),
    .rdata_o(rdata), .dmem_req_o(mreq), .dmem_we_o(mwe), .dmem_add_o(madd),
    .dmem_di_o(mdi), .dmem_ble_o(mble), .dmem_ack_i(ack), .dmem_do_i(do_i)
  );

  rv32i_lsu #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1'b0)) u_dut_nomis (
    .clk_i(clk), .resetn_i(resetn), .req_i(req_n), .we_i(we), .func3_i(f3),
    .addr_i(addr), .wdata_i(wdata), .busy_o(n_busy), .done_o(n_done), .err_o(n_err),
    .rdata_o(n_rdata), .dmem_req_o(n_mreq), .dmem_we_o(n_mwe), .dmem_add_o(n_madd),
    .dmem_di_o(n_mdi), .dmem_ble_o(n_mble), .dmem_ack_i(ack), .dmem_do_i(do_i)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one access on u_dut, answer each memory transaction after dly idle
  // cycles, and check port contents at every step plus the final response.
  task automatic access(input string tag, input logic w, input logic [2:0] fn,
                        input logic [31:0] a, input logic [31:0] wd, input int nacc,
                        input logic [31:0] a1, input logic [3:0] b1, input logic [31:0] d1,
                        input logic [31:0] r1, input logic [31:0] a2, input logic [3:0] b2,
                        input logic [31:0] d2, input logic [31:0] r2,
                        input logic [31:0] rexp, input int dly);
    logic [31:0] ea, ed;
    logic [3:0]  eb;
    req = 1'b1; we = w; f3 = fn; addr = a; wdata = wd;
    #1;
    check_val({tag, "_busy_accept"}, 32'(busy), 32'd1);
    tick();
    req = 1'b0;
    for (int k = 0; k < nacc; k++) begin
      ea = (k == 0) ? a1 : a2;
      eb = (k == 0) ? b1 : b2;
      ed = (k == 0) ? d1 : d2;
      for (int j = 0; j < dly; j++) begin
        check_val({tag, "_hold_req"}, 32'(mreq), 32'd1);
        check_val({tag, "_hold_add"}, madd, ea);
        check_val({tag, "_hold_ble"}, 32'(mble), 32'(eb));
        check_val({tag, "_hold_busy"}, 32'(busy), 32'd1);
        check_val({tag, "_hold_done"}, 32'(done), 32'd0);
        if (w) check_val({tag, "_hold_di"}, mdi, ed);
        tick();
      end
      check_val({tag, "_req"}, 32'(mreq), 32'd1);
      check_val({tag, "_add"}, madd, ea);
      check_val({tag, "_ble"}, 32'(mble), 32'(eb));
      check_val({tag, "_we"}, 32'(mwe), 32'(w));
      check_val({tag, "_busy"}, 32'(busy), 32'd1);
      check_val({tag, "_nodone"}, 32'(done), 32'd0);
      if (w) check_val({tag, "_di"}, mdi, ed);
      ack = 1'b1;
      do_i = (k == 0) ? r1 : r2;
      tick();
      ack = 1'b0;
    end
    check_val({tag, "_done"}, 32'(done), 32'd1);
    check_val({tag, "_err"}, 32'(err), 32'd0);
    check_val({tag, "_rdata"}, rdata, rexp);
    check_val({tag, "_req_off"}, 32'(mreq), 32'd0);
  endtask

  // Issue a request that must be refused: done/err one cycle later, no memory request.
  task automatic bad_access(input string tag, input bit nomis, input logic w,
                            input logic [2:0] fn, input logic [31:0] a);
    we = w; f3 = fn; addr = a; wdata = 32'hFFFF_FFFF;
    if (nomis) req_n = 1'b1; else req = 1'b1;
    #1;
    check_val({tag, "_busy"}, 32'(nomis ? n_busy : busy), 32'd0);
    tick();
    req = 1'b0; req_n = 1'b0;
    check_val({tag, "_done"}, 32'(nomis ? n_done : done), 32'd1);
    check_val({tag, "_err"}, 32'(nomis ? n_err : err), 32'd1);
    check_val({tag, "_rdata"}, nomis ? n_rdata : rdata, 32'd0);
    check_val({tag, "_mreq"}, 32'(nomis ? n_mreq : mreq), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; req = 1'b1; req_n = 1'b0; we = 1'b0; f3 = 3'b010;
    addr = 32'h100; wdata = 32'd0; ack = 1'b0; do_i = 32'd0;
    #12;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_mreq", 32'(mreq), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_ble", 32'(mble), 32'd0);
    tick();
    resetn = 1'b1; req = 1'b0;

    // First cycle after release accepts; byte loads sign/zero extended.
    access("lb", 1'b0, 3'b000, 32'h103, 32'd0, 1, 32'h100, 4'b1000, 32'd0, 32'h8000_0000,
           32'd0, 4'b0000, 32'd0, 32'd0, 32'hFFFF_FF80, 0);
    tick();
    check_val("lb_done_pulse", 32'(done), 32'd0);
    access("lbu", 1'b0, 3'b100, 32'h103, 32'd0, 1, 32'h100, 4'b1000, 32'd0, 32'h8000_0000,
           32'd0, 4'b0000, 32'd0, 32'd0, 32'h0000_0080, 0);
    tick();
    // Split word load across two words.
    access("lw_split", 1'b0, 3'b010, 32'h102, 32'd0, 2, 32'h100, 4'b1100, 32'd0, 32'h4433_2211,
           32'h104, 4'b0011, 32'd0, 32'h8877_6655, 32'h6655_4433, 0);
    tick();
    // Split halfword store, then byte store with junk in upper data bits.
    access("sh_split", 1'b1, 3'b001, 32'h103, 32'h0000_ABCD, 2, 32'h100, 4'b1000, 32'hCD00_0000,
           32'd0, 32'h104, 4'b0001, 32'h0000_00AB, 32'd0, 32'd0, 0);
    tick();
    access("sb", 1'b1, 3'b000, 32'h101, 32'h1234_56EF, 1, 32'h100, 4'b0010, 32'h0000_EF00,
           32'd0, 32'd0, 4'b0000, 32'd0, 32'd0, 32'd0, 0);
    tick();
    // Split signed halfword load.
    access("lh_split", 1'b0, 3'b001, 32'h103, 32'd0, 2, 32'h100, 4'b1000, 32'd0, 32'hAA00_0000,
           32'h104, 4'b0001, 32'd0, 32'h0000_00BB, 32'hFFFF_BBAA, 0);
    tick();
    // Delayed acks, then a back-to-back request issued in RESP.
    access("lhu_dly", 1'b0, 3'b101, 32'h106, 32'd0, 1, 32'h104, 4'b1100, 32'd0, 32'hF00D_BEEF,
           32'd0, 4'b0000, 32'd0, 32'd0, 32'h0000_F00D, 3);
    tick();
    access("sw_dly", 1'b1, 3'b010, 32'h208, 32'hDEAD_BEEF, 1, 32'h208, 4'b1111, 32'hDEAD_BEEF,
           32'd0, 32'd0, 4'b0000, 32'd0, 32'd0, 32'd0, 3);
    access("lb_b2b", 1'b0, 3'b000, 32'h101, 32'd0, 1, 32'h100, 4'b0010, 32'd0, 32'h0000_7F00,
           32'd0, 4'b0000, 32'd0, 32'd0, 32'h0000_007F, 0);

    // Refused encodings, the first issued straight from RESP.
    bad_access("err_f3_011", 1'b0, 1'b0, 3'b011, 32'h100);
    bad_access("err_f3_111", 1'b0, 1'b0, 3'b111, 32'h100);
    bad_access("err_sbu", 1'b0, 1'b1, 3'b100, 32'h100);
    bad_access("err_f3_110", 1'b0, 1'b0, 3'b110, 32'h100);
    tick();
    bad_access("nomis_lw", 1'b1, 1'b0, 3'b010, 32'h102);
    tick();

    // Reset while the second half of a split load is outstanding.
    req = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h102;
    tick();
    req = 1'b0; ack = 1'b1; do_i = 32'h4433_2211;
    tick();
    ack = 1'b0;
    check_val("rst_acc2_pre_req", 32'(mreq), 32'd1);
    check_val("rst_acc2_pre_add", madd, 32'h104);
    resetn = 1'b0;
    #1;
    check_val("rst_acc2_mreq", 32'(mreq), 32'd0);
    check_val("rst_acc2_busy", 32'(busy), 32'd0);
    tick();
    tick();
    check_val("rst_acc2_nodone", 32'(done), 32'd0);
    resetn = 1'b1;
    tick();
    check_val("rst_acc2_idle_done", 32'(done), 32'd0);
    check_val("rst_acc2_idle_mreq", 32'(mreq), 32'd0);
    check_val("rst_acc2_idle_busy", 32'(busy), 32'd0);
    access("post_rst_lbu", 1'b0, 3'b100, 32'h103, 32'd0, 1, 32'h100, 4'b1000, 32'd0, 32'h8000_0000,
           32'd0, 4'b0000, 32'd0, 32'd0, 32'h0000_0080, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
